// File: rtl/dmux_stream.sv
//==============================================================================
// Module      : dmux_stream
// Description : Registered 1-to-N stream demultiplexer with per-channel slots.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module dmux_stream #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 3,
    parameter int CHANNELS = 2**SEL_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_BITS-1:0]       in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [15:0]               xfer_count
);

    logic [CHANNELS-1:0] w_free;
    logic [CHANNELS-1:0] w_load;
    logic                w_accept;
    logic [15:0]         r_xfer_count;

    // Broadcast needs every slot free at once so delivery is all-or-nothing.
    assign in_ready   = in_bcast ? (&w_free) : w_free[in_sel];
    assign w_accept   = in_valid & in_ready;
    assign xfer_count = r_xfer_count;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            assign w_free[k] = ~r_valid | out_ready[k];
            assign w_load[k] = w_accept & (in_bcast | (in_sel == SEL_BITS'(k)));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[k]) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid <= 1'b0;
                end
            end

            assign out_valid[k]                  = r_valid;
            assign out_data[k*WIDTH +: WIDTH]    = r_data;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_xfer_count <= '0;
        end else if (w_accept) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmux_stream.sv
//==============================================================================
// Module      : tb_dmux_stream
// Description : Scoreboard bench for dmux_stream plus two parameter variants.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_dmux_stream;

    localparam int W  = 16;
    localparam int SB = 3;
    localparam int CH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic              in_valid, in_ready, in_bcast;
    logic [W-1:0]      in_data;
    logic [SB-1:0]     in_sel;
    logic [CH-1:0]     out_valid, out_ready;
    logic [CH*W-1:0]   out_data;
    logic [15:0]       xfer_count;

    dmux_stream #(.WIDTH(W), .SEL_BITS(SB)) u_dut (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_count(xfer_count)
    );

    // SEL_BITS=1, WIDTH=1 variant
    logic        a_valid, a_ready, a_bcast, a_sel;
    logic [0:0]  a_data;
    logic [1:0]  a_out_valid, a_out_ready, a_out_data;
    logic [15:0] a_count;

    dmux_stream #(.WIDTH(1), .SEL_BITS(1)) u_dut_a (
        .clock(clk), .reset(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sel(a_sel), .in_bcast(a_bcast),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .xfer_count(a_count)
    );

    // SEL_BITS=4, WIDTH=32 variant
    logic         b_valid, b_ready, b_bcast;
    logic [31:0]  b_data;
    logic [3:0]   b_sel;
    logic [15:0]  b_out_valid, b_out_ready;
    logic [511:0] b_out_data;
    logic [15:0]  b_count;

    dmux_stream #(.WIDTH(32), .SEL_BITS(4)) u_dut_b (
        .clock(clk), .reset(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_sel(b_sel), .in_bcast(b_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .xfer_count(b_count)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q [CH][$];
    logic [15:0]  model_cnt = '0;
    int           n_drain7 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard step: predict ready, pop drained words, push accepted words,
    // advance one clock and compare slot state against the model.
    task automatic step();
        logic          exp_ready;
        logic [CH-1:0] free_v;
        logic [CH-1:0] exp_v;
        #1;
        for (int k = 0; k < CH; k++)
            free_v[k] = (exp_q[k].size() == 0) || out_ready[k];
        exp_ready = in_bcast ? (&free_v) : free_v[in_sel];
        check("in_ready", in_ready, exp_ready);
        for (int k = 0; k < CH; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                if (exp_q[k].size() != 0) begin
                    check($sformatf("drain_data%0d", k), out_data[k*W +: W], exp_q[k][0]);
                    void'(exp_q[k].pop_front());
                    if (k == 7) n_drain7++;
                end else begin
                    check($sformatf("drain_unexpected%0d", k), 64'(exp_q[k].size()), 64'd1);
                end
            end
        end
        if (in_valid && exp_ready) begin
            for (int k = 0; k < CH; k++)
                if (in_bcast || in_sel == SB'(k)) exp_q[k].push_back(in_data);
            model_cnt = model_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) exp_v[k] = (exp_q[k].size() != 0);
        check("out_valid", out_valid, exp_v);
        for (int k = 0; k < CH; k++)
            if (exp_q[k].size() != 0)
                check($sformatf("out_data%0d", k), out_data[k*W +: W], exp_q[k][0]);
        check("xfer_count", xfer_count, model_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < CH; k++) exp_q[k].delete();
        model_cnt = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_bcast = 0; in_data = '0; in_sel = '0; out_ready = '0;
        a_valid = 0; a_bcast = 0; a_data = '0; a_sel = 0; a_out_ready = '0;
        b_valid = 0; b_bcast = 0; b_data = '0; b_sel = '0; b_out_ready = '0;
        #3;
        do_reset();

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data[63:0], 0);
        check("rst_count", xfer_count, 0);
        in_sel = 3'd6;
        #1;
        check("rst_ready", in_ready, 1);

        // Unicast to sel 5, consumers stalled
        in_valid = 1; in_data = 16'h1234; in_sel = 3'd5;
        step();
        check("uni_valid", out_valid, 8'b0010_0000);
        check("uni_data5", out_data[5*W +: W], 16'h1234);
        check("uni_count", xfer_count, 16'd1);
        #1;
        check("uni_sel5_busy", in_ready, 0);
        step();
        in_sel = 3'd2;
        step();
        check("uni_sel2_valid", out_valid, 8'b0010_0100);
        in_valid = 0;

        // Stall hold on channel 3
        in_valid = 1; in_data = 16'hBEEF; in_sel = 3'd3;
        step();
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_data3", out_data[3*W +: W], 16'hBEEF);
        end
        out_ready[3] = 1'b1;
        step();
        check("hold_release", out_valid[3], 0);
        out_ready = '0;

        // Streaming on channel 7
        do_reset();
        n_drain7 = 0;
        in_sel = 3'd7; out_ready[7] = 1'b1; in_valid = 1;
        for (int i = 1; i <= 20; i++) begin
            in_data = W'(i);
            step();
            check("stream_v7", out_valid[7], 1);
            check("stream_d7", out_data[7*W +: W], 16'(i));
        end
        in_valid = 0;
        step();
        check("stream_count", xfer_count, 16'd20);
        check("stream_drains", 64'(n_drain7), 64'd20);
        out_ready = '0;

        // Broadcast blocked by a full channel 0
        do_reset();
        in_valid = 1; in_sel = 3'd0; in_data = 16'h0055;
        step();
        in_bcast = 1; in_data = 16'h00AA; in_sel = 3'd4;
        #1;
        check("bcast_blocked", in_ready, 0);
        step();
        check("bcast_nochange", out_valid, 8'b0000_0001);
        out_ready[0] = 1'b1;
        step();
        in_valid = 0; in_bcast = 0; out_ready = '0;
        check("bcast_all_valid", out_valid, 8'hFF);
        for (int k = 0; k < CH; k++)
            check($sformatf("bcast_data%0d", k), out_data[k*W +: W], 16'h00AA);
        step();

        // Counter wrap over 65536 accepts
        do_reset();
        out_ready = '1; in_valid = 1;
        for (int i = 0; i < 65536; i++) begin
            in_sel  = SB'(i);
            in_data = W'(i);
            step();
        end
        in_valid = 0;
        step();
        check("wrap_count", xfer_count, 16'd0);
        out_ready = '0;

        // Asynchronous reset with four slots full
        do_reset();
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_sel = SB'(i); in_data = 16'hA000 + 16'(i);
            step();
        end
        in_valid = 0;
        check("async_pre_count", xfer_count, 16'd4);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_count", xfer_count, 0);
        check("async_data0", out_data[W-1:0], 0);
        for (int k = 0; k < CH; k++) exp_q[k].delete();
        model_cnt = '0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();

        // Parameter sweep: SEL_BITS=1, WIDTH=1
        a_valid = 1; a_data = 1'b1; a_sel = 1'b1;
        @(posedge clk); #1;
        check("a_valid", a_out_valid, 2'b10);
        check("a_data1", a_out_data[1], 1);
        check("a_count", a_count, 16'd1);
        check("a_busy", a_ready, 0);
        a_sel = 1'b0;
        #1;
        check("a_free0", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 0;
        check("a_valid2", a_out_valid, 2'b11);
        check("a_count2", a_count, 16'd2);

        // Parameter sweep: SEL_BITS=4, WIDTH=32
        b_valid = 1; b_data = 32'hDEAD_1234; b_sel = 4'd13;
        @(posedge clk); #1;
        check("b_valid", b_out_valid, 16'h2000);
        check("b_data13", b_out_data[13*32 +: 32], 32'hDEAD_1234);
        check("b_count", b_count, 16'd1);
        check("b_busy", b_ready, 0);
        b_sel = 4'd2;
        #1;
        check("b_free2", b_ready, 1);
        @(posedge clk); #1;
        b_valid = 0;
        check("b_valid2", b_out_valid, 16'h2004);
        check("b_data2", b_out_data[2*32 +: 32], 32'hDEAD_1234);
        check("b_count2", b_count, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
